runner_sprite_ctrl: RTL and testbench
=====================================

// Module: runner_sprite_ctrl
// PURPOSE
//  Next-generation player controller for the runner game. Holds the player's
//  position, signed vertical velocity and animation page per frame, and adds
//  gravity physics, double jump, duck, death freeze and an externally
//  addressed sprite ROM. Sits between keyboard/game FSM and the colour mapper.
// PARAMETERS
//  X_LEFT      100    fixed player left X (0..639)
//  Y_RESET     250    player top Y applied by reset
//  Y_MIN       10     ceiling; player top never goes above this
//  WIDTH       56     sprite width, px
//  HEIGHT      80     standing/jumping height, px; also ROM rows per page
//  DUCK_HEIGHT 48     ducking height, px (must be <= HEIGHT)
//  JUMP_V0     12     jump launch speed, px/frame (upward)
//  GRAVITY     1      velocity increment per frame (doubled while duck held in air)
//  V_MAX       12     terminal fall speed, px/frame
//  RUN_PAGES   9      run-cycle pages; AIR=RUN_PAGES, DUCK=+1, DEAD=+2
//  FRAME_DIV   2      frames per run page
//  MAX_JUMPS   2      jumps allowed before landing
//  KEY_JUMP    8'h2C  jump keycode;  KEY_DUCK 8'h51 duck keycode
// PORTS
//  Clk            in   1       50 MHz system clock
//  Reset_n        in   1       asynchronous, active-low reset
//  frame_clk      in   1       ~60 Hz frame strobe (async level)
//  playing        in   1       game running
//  hit            in   1       collision from obstacle logic
//  keycode        in   8       last received key
//  DrawX, DrawY   in   10      current pixel
//  GroundY        in   10      floor height
//  sprite_row     in   WIDTH   ROM data for sprite_addr; MSB = leftmost column
//  sprite_addr    out  11      page*HEIGHT + (DrawY - Y_Pos)
//  is_player      out  1       current pixel is an opaque player pixel
//  PlayerTop      out  10      Y_Pos
//  PlayerBottom   out  10      Y_Pos + current height
//  state_o        out  3       IDLE=0 RUN=1 AIR=2 DUCK=3 DEAD=4
// BEHAVIOUR
//  - One clock, Clk; asynchronous, active-low reset Reset_n.
//  - Reset: state IDLE, Y_Pos=Y_RESET, vel=0, jumps=0, page=0, sub-count=0,
//    key_prev=0, edge regs=0. So PlayerTop=Y_RESET, PlayerBottom=Y_RESET+HEIGHT.
//  - tick = registered rising edge of frame_clk. It is seen 2 Clk cycles after
//    the frame_clk edge. All state updates occur on tick only.
//  - jump_edge = (keycode==KEY_JUMP) && !key_prev. key_prev samples on tick.
//    A held key never re-triggers a jump. duck_held = (keycode==KEY_DUCK).
//  - Math uses 11-bit signed; vel is positive downward, clamped to [-JUMP_V0, V_MAX].
//  - Priority per tick: !playing > hit > state rules.
//  - !playing (any state): next IDLE, Y=GroundY-HEIGHT, vel=0, jumps=0, page=0.
//  - hit (playing): next DEAD; position and velocity are frozen.
//  - IDLE: next RUN. Y snaps to GroundY-HEIGHT.
//  - RUN: Y tracks GroundY-HEIGHT every tick.
//    - jump_edge: next AIR, vel=-JUMP_V0, jumps=1, Y unchanged this tick.
//    - else if duck_held: next DUCK.
//    - Run page advances every FRAME_DIV ticks and wraps RUN_PAGES-1 -> 0.
//  - AIR: Y += vel, then vel += GRAVITY (2*GRAVITY if duck_held), saturating at V_MAX.
//    - jump_edge && jumps<MAX_JUMPS: vel=-JUMP_V0, jumps++, Y unchanged.
//    - Ceiling: if Y+vel < Y_MIN, then Y=Y_MIN and vel=0.
//    - Landing: if Y+vel+HEIGHT >= GroundY (this includes GroundY rising past
//      the feet), then Y=GroundY-HEIGHT, vel=0, jumps=0; next DUCK if duck_held,
//      else RUN. Never overshoots the floor.
//  - DUCK: height=DUCK_HEIGHT and Y=GroundY-DUCK_HEIGHT.
//    - jump_edge: AIR, same as the RUN launch, Y back to HEIGHT basis.
//    - !duck_held: next RUN.
//  - DEAD: hold until !playing.
//  - Page selection: IDLE 0, RUN counter, AIR RUN_PAGES, DUCK RUN_PAGES+1,
//    DEAD RUN_PAGES+2. Leaving RUN keeps the run counter; re-entering RUN resumes it.
//  - Pixel path: combinational from DrawX/DrawY and registered state, zero latency,
//    so the ROM must be asynchronous.
//    - x=DrawX-X_LEFT, y=DrawY-Y_Pos (signed).
//    - is_player = 0<=x<WIDTH && 0<=y<cur_height && sprite_row[WIDTH-1-x].
//    - sprite_addr is don't-care outside the box.
// TESTING
//  1. Reset_n low, then playing=1, GroundY=330, ticks -> RUN after 1 tick, Y=250,
//     page 0,0,1,1..8,8,0.
//  2. Single 0x2C press while in RUN -> Y 250,238,227..172 (vel 0), then descent;
//     lands at exactly Y=250, jumps=0, RUN.
//  3. Space held through the whole jump -> no relaunch. Press/release/press in AIR
//     -> second launch vel=-12; a third press is ignored until landing.
//  4. 0x51 held in RUN -> DUCK, PlayerTop=282, PlayerBottom=330, page 10.
//     Release -> RUN, PlayerTop=250.
//  5. hit during AIR -> DEAD, Y frozen, page 11, is_player still drawn.
//     playing=0 -> IDLE, Y=250.
//  6. Reset_n pulsed between Clk edges mid-jump -> state_o=0, PlayerTop=250
//     immediately, with no Clk edge needed.

Source files
------------

// File: rtl/runner_sprite_ctrl.sv
// runner_sprite_ctrl: per-frame player controller for the runner game.
// Holds the player's vertical position, signed velocity, jump budget and run
// animation counter. Everything advances once per frame tick, derived from the
// asynchronous frame strobe. A zero-latency pixel path tells the colour mapper
// whether the current pixel is an opaque player pixel and which asynchronous
// sprite ROM row to fetch.
module runner_sprite_ctrl #(
  parameter int          X_LEFT      = 100,
  parameter int          Y_RESET     = 250,
  parameter int          Y_MIN       = 10,
  parameter int          WIDTH       = 56,
  parameter int          HEIGHT      = 80,
  parameter int          DUCK_HEIGHT = 48,
  parameter int          JUMP_V0     = 12,
  parameter int          GRAVITY     = 1,
  parameter int          V_MAX       = 12,
  parameter int          RUN_PAGES   = 9,
  parameter int          FRAME_DIV   = 2,
  parameter int          MAX_JUMPS   = 2,
  parameter logic [7:0]  KEY_JUMP    = 8'h2C,
  parameter logic [7:0]  KEY_DUCK    = 8'h51
) (
  input  logic             Clk,
  input  logic             Reset_n,
  input  logic             frame_clk,
  input  logic             playing,
  input  logic             hit,
  input  logic [7:0]       keycode,
  input  logic [9:0]       DrawX,
  input  logic [9:0]       DrawY,
  input  logic [9:0]       GroundY,
  input  logic [WIDTH-1:0] sprite_row,
  output logic [10:0]      sprite_addr,
  output logic             is_player,
  output logic [9:0]       PlayerTop,
  output logic [9:0]       PlayerBottom,
  output logic [2:0]       state_o
);

  // Player states, numbered as the game FSM and colour mapper expect them.
  localparam logic [2:0] S_IDLE = 3'd0;
  localparam logic [2:0] S_RUN  = 3'd1;
  localparam logic [2:0] S_AIR  = 3'd2;
  localparam logic [2:0] S_DUCK = 3'd3;
  localparam logic [2:0] S_DEAD = 3'd4;

  // All position/velocity math is 11-bit signed so that y - vel and
  // DrawY - y can go negative without wrapping.
  typedef logic signed [10:0] s11_t;

  localparam s11_t C_X_LEFT  = s11_t'(X_LEFT);
  localparam s11_t C_Y_RESET = s11_t'(Y_RESET);
  localparam s11_t C_Y_MIN   = s11_t'(Y_MIN);
  localparam s11_t C_WIDTH   = s11_t'(WIDTH);
  localparam s11_t C_HEIGHT  = s11_t'(HEIGHT);
  localparam s11_t C_DUCK_H  = s11_t'(DUCK_HEIGHT);
  localparam s11_t C_JUMP_V0 = s11_t'(JUMP_V0);
  localparam s11_t C_GRAVITY = s11_t'(GRAVITY);
  localparam s11_t C_V_MAX   = s11_t'(V_MAX);

  localparam logic [7:0] SUB_LAST   = 8'(FRAME_DIV - 1);
  localparam logic [7:0] PAGE_LAST  = 8'(RUN_PAGES - 1);
  localparam logic [7:0] PAGE_AIR   = 8'(RUN_PAGES);
  localparam logic [7:0] PAGE_DUCK  = 8'(RUN_PAGES + 1);
  localparam logic [7:0] PAGE_DEAD  = 8'(RUN_PAGES + 2);
  localparam logic [3:0] JUMPS_MAX  = 4'(MAX_JUMPS);
  localparam int         COL_W      = $clog2(WIDTH);

  // Frame strobe synchroniser and registered tick.
  logic fc_d1, fc_d2, tick;

  // Registered player state.
  logic [2:0] state;
  s11_t       y_pos;
  s11_t       vel;
  logic [3:0] jumps;
  logic [7:0] run_page;
  logic [7:0] sub_cnt;
  logic       key_prev;

  // Next-state values, applied on tick.
  logic [2:0] state_n;
  s11_t       y_n;
  s11_t       vel_n;
  logic [3:0] jumps_n;
  logic [7:0] page_n;
  logic [7:0] sub_n;

  // Per-tick helper terms.
  s11_t ground, y_stand, y_duck, y_step, grav, vel_sum, vel_fall;
  logic jump_edge, duck_held;

  // Pixel-path terms.
  s11_t       cur_h, x_off, y_off;
  logic [7:0] cur_page;
  logic       in_box;
  logic [WIDTH-1:0] row_shift;

  // Bring the frame strobe into the Clk domain and form a one-cycle tick on its rising edge.
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      fc_d1 <= 1'b0;
      fc_d2 <= 1'b0;
      tick  <= 1'b0;
    end else begin
      // NOTE: registers are written with <= so each one updates from the values held before this edge.
      fc_d1 <= frame_clk;
      fc_d2 <= fc_d1;
      tick  <= fc_d1 & ~fc_d2;
    end
  end

  // Key and physics helper terms shared by the next-state logic.
  always_comb begin
    ground    = s11_t'({1'b0, GroundY});
    y_stand   = ground - C_HEIGHT;
    y_duck    = ground - C_DUCK_H;
    jump_edge = (keycode == KEY_JUMP) && !key_prev;
    duck_held = (keycode == KEY_DUCK);
    y_step    = y_pos + vel;
    grav      = duck_held ? (C_GRAVITY + C_GRAVITY) : C_GRAVITY;
    vel_sum   = vel + grav;
    vel_fall  = (vel_sum > C_V_MAX) ? C_V_MAX : vel_sum;
  end

  // Next-state rules: !playing beats hit, hit beats the per-state rules.
  always_comb begin
    // NOTE: every output of this block gets its hold value first, so no branch can leave one unassigned and infer a latch.
    state_n = state;
    y_n     = y_pos;
    vel_n   = vel;
    jumps_n = jumps;
    page_n  = run_page;
    sub_n   = sub_cnt;
    if (!playing) begin
      state_n = S_IDLE;
      y_n     = y_stand;
      vel_n   = '0;
      jumps_n = '0;
      page_n  = '0;
      sub_n   = '0;
    end else if (hit) begin
      state_n = S_DEAD;
    end else begin
      case (state)
        S_IDLE: begin
          state_n = S_RUN;
          y_n     = y_stand;
        end
        S_RUN: begin
          if (sub_cnt == SUB_LAST) begin
            sub_n  = '0;
            page_n = (run_page == PAGE_LAST) ? 8'd0 : run_page + 8'd1;
          end else begin
            sub_n  = sub_cnt + 8'd1;
          end
          y_n = y_stand;
          if (jump_edge) begin
            state_n = S_AIR;
            vel_n   = -C_JUMP_V0;
            jumps_n = 4'd1;
          end else if (duck_held) begin
            state_n = S_DUCK;
            y_n     = y_duck;
          end
        end
        S_AIR: begin
          if (jump_edge && (jumps < JUMPS_MAX)) begin
            vel_n   = -C_JUMP_V0;
            jumps_n = jumps + 4'd1;
          end else if (y_step + C_HEIGHT >= ground) begin
            // Land flush on the floor; the landing Y follows the height of the state we land in.
            vel_n   = '0;
            jumps_n = '0;
            if (duck_held) begin
              state_n = S_DUCK;
              y_n     = y_duck;
            end else begin
              state_n = S_RUN;
              y_n     = y_stand;
            end
          end else if (y_step < C_Y_MIN) begin
            y_n   = C_Y_MIN;
            vel_n = '0;
          end else begin
            y_n   = y_step;
            vel_n = vel_fall;
          end
        end
        S_DUCK: begin
          if (jump_edge) begin
            state_n = S_AIR;
            vel_n   = -C_JUMP_V0;
            jumps_n = 4'd1;
            y_n     = y_stand;
          end else if (!duck_held) begin
            state_n = S_RUN;
            y_n     = y_stand;
          end else begin
            y_n     = y_duck;
          end
        end
        default: begin
          // DEAD (and any unused code) freezes until the game stops.
        end
      endcase
    end
  end

  // Player state register; advances only on the frame tick.
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      state    <= S_IDLE;
      y_pos    <= C_Y_RESET;
      vel      <= '0;
      jumps    <= '0;
      run_page <= '0;
      sub_cnt  <= '0;
      key_prev <= 1'b0;
    end else if (tick) begin
      state    <= state_n;
      y_pos    <= y_n;
      vel      <= vel_n;
      jumps    <= jumps_n;
      run_page <= page_n;
      sub_cnt  <= sub_n;
      key_prev <= (keycode == KEY_JUMP);
    end
  end

  // Current height and sprite page selected by state.
  always_comb begin
    cur_h = (state == S_DUCK) ? C_DUCK_H : C_HEIGHT;
    case (state)
      S_RUN:   cur_page = run_page;
      S_AIR:   cur_page = PAGE_AIR;
      S_DUCK:  cur_page = PAGE_DUCK;
      S_DEAD:  cur_page = PAGE_DEAD;
      default: cur_page = 8'd0;
    endcase
  end

  // Zero-latency pixel path: box test, ROM address and column pick from the asynchronous ROM row.
  always_comb begin
    x_off       = s11_t'({1'b0, DrawX}) - C_X_LEFT;
    y_off       = s11_t'({1'b0, DrawY}) - y_pos;
    in_box      = (x_off >= 0) && (x_off < C_WIDTH) && (y_off >= 0) && (y_off < cur_h);
    // Shifting left by the column brings column x (counted from the MSB) to the MSB.
    row_shift   = sprite_row << x_off[COL_W-1:0];
    is_player   = in_box && row_shift[WIDTH-1];
    sprite_addr = 11'(int'(cur_page) * HEIGHT) + y_off;
  end

  assign PlayerTop    = y_pos[9:0];
  assign PlayerBottom = 10'(y_pos + cur_h);
  assign state_o      = state;

endmodule

// File: tb/tb_runner_sprite_ctrl.sv
// Self-checking bench for runner_sprite_ctrl: directed scenarios from the
// game rules followed by randomized frames, all compared against a behavioural
// model of the player that works in plain integers.
module tb_runner_sprite_ctrl;

  localparam int X_LEFT      = 100;
  localparam int Y_RESET     = 250;
  localparam int Y_MIN       = 10;
  localparam int WIDTH       = 56;
  localparam int HEIGHT      = 80;
  localparam int DUCK_HEIGHT = 48;
  localparam int JUMP_V0     = 12;
  localparam int GRAVITY     = 1;
  localparam int V_MAX       = 12;
  localparam int RUN_PAGES   = 9;
  localparam int FRAME_DIV   = 2;
  localparam int MAX_JUMPS   = 2;
  localparam logic [7:0] K_JUMP = 8'h2C;
  localparam logic [7:0] K_DUCK = 8'h51;

  localparam int ST_IDLE = 0, ST_RUN = 1, ST_AIR = 2, ST_DUCK = 3, ST_DEAD = 4;

  logic             Clk = 1'b0;
  logic             Reset_n = 1'b0;
  logic             frame_clk = 1'b0;
  logic             playing = 1'b0;
  logic             hit = 1'b0;
  logic [7:0]       keycode = 8'h00;
  logic [9:0]       DrawX = '0;
  logic [9:0]       DrawY = '0;
  logic [9:0]       GroundY = 10'd330;
  logic [WIDTH-1:0] sprite_row = '0;
  logic [10:0]      sprite_addr;
  logic             is_player;
  logic [9:0]       PlayerTop;
  logic [9:0]       PlayerBottom;
  logic [2:0]       state_o;

  runner_sprite_ctrl dut (
    .Clk          (Clk),
    .Reset_n      (Reset_n),
    .frame_clk    (frame_clk),
    .playing      (playing),
    .hit          (hit),
    .keycode      (keycode),
    .DrawX        (DrawX),
    .DrawY        (DrawY),
    .GroundY      (GroundY),
    .sprite_row   (sprite_row),
    .sprite_addr  (sprite_addr),
    .is_player    (is_player),
    .PlayerTop    (PlayerTop),
    .PlayerBottom (PlayerBottom),
    .state_o      (state_o)
  );

  always #10 Clk = ~Clk;

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Behavioural player model: integer physics, run page from a count of RUN frames.
  int m_state, m_y, m_v, m_jumps, m_run_frames;
  bit m_key_prev;

  function automatic int m_height();
    return (m_state == ST_DUCK) ? DUCK_HEIGHT : HEIGHT;
  endfunction

  function automatic int m_page();
    case (m_state)
      ST_RUN:  return (m_run_frames / FRAME_DIV) % RUN_PAGES;
      ST_AIR:  return RUN_PAGES;
      ST_DUCK: return RUN_PAGES + 1;
      ST_DEAD: return RUN_PAGES + 2;
      default: return 0;
    endcase
  endfunction

  task automatic model_reset();
    m_state = ST_IDLE; m_y = Y_RESET; m_v = 0; m_jumps = 0;
    m_run_frames = 0; m_key_prev = 1'b0;
  endtask

  task automatic launch(input int g);
    m_state = ST_AIR; m_v = -JUMP_V0; m_jumps = 1; m_y = g - HEIGHT;
  endtask

  task automatic model_frame(input logic [7:0] key, input bit play, input bit hv, input int g);
    bit je, dh;
    int ny;
    je = (key == K_JUMP) && !m_key_prev;
    dh = (key == K_DUCK);
    if (!play) begin
      m_state = ST_IDLE; m_y = g - HEIGHT; m_v = 0; m_jumps = 0; m_run_frames = 0;
    end else if (hv) begin
      m_state = ST_DEAD;
    end else begin
      case (m_state)
        ST_IDLE: begin m_state = ST_RUN; m_y = g - HEIGHT; end
        ST_RUN: begin
          m_run_frames++;
          if (je) launch(g);
          else if (dh) begin m_state = ST_DUCK; m_y = g - DUCK_HEIGHT; end
          else m_y = g - HEIGHT;
        end
        ST_AIR: begin
          ny = m_y + m_v;
          if (je && m_jumps < MAX_JUMPS) begin
            m_v = -JUMP_V0; m_jumps++;
          end else if (ny + HEIGHT >= g) begin
            m_v = 0; m_jumps = 0;
            if (dh) begin m_state = ST_DUCK; m_y = g - DUCK_HEIGHT; end
            else begin m_state = ST_RUN; m_y = g - HEIGHT; end
          end else if (ny < Y_MIN) begin
            m_y = Y_MIN; m_v = 0;
          end else begin
            m_y = ny;
            m_v = m_v + (dh ? 2 * GRAVITY : GRAVITY);
            if (m_v > V_MAX) m_v = V_MAX;
          end
        end
        ST_DUCK: begin
          if (je) launch(g);
          else if (!dh) begin m_state = ST_RUN; m_y = g - HEIGHT; end
          else m_y = g - DUCK_HEIGHT;
        end
        default: ;
      endcase
    end
    m_key_prev = (key == K_JUMP);
  endtask

  // Compare the per-frame outputs and probe a few pixels around the player box.
  task automatic compare_outputs();
    int px, py, xo, yo;
    bit inb;
    logic [WIDTH-1:0] row;
    check("state", 32'(state_o), 32'(m_state));
    check("top", 32'(PlayerTop), 32'(m_y));
    check("bottom", 32'(PlayerBottom), 32'(m_y + m_height()));
    for (int k = 0; k < 3; k++) begin
      px  = X_LEFT - 4 + int'($urandom_range(WIDTH + 7));
      py  = m_y - 4 + int'($urandom_range(m_height() + 7));
      row = {$urandom, $urandom};
      DrawX = px[9:0]; DrawY = py[9:0]; sprite_row = row;
      #1;
      xo  = px - X_LEFT;
      yo  = py - m_y;
      inb = (xo >= 0) && (xo < WIDTH) && (yo >= 0) && (yo < m_height());
      check("is_player", 32'(is_player), 32'(inb && row[WIDTH-1-xo]));
      if (inb) check("sprite_addr", 32'(sprite_addr), 32'(m_page() * HEIGHT + yo));
    end
  endtask

  // One frame: set inputs, pulse the frame strobe, let the tick land, then check.
  task automatic frame(input logic [7:0] key, input bit play, input bit hv, input int g);
    @(negedge Clk);
    keycode = key; playing = play; hit = hv; GroundY = g[9:0];
    frame_clk = 1'b1;
    repeat (4) @(negedge Clk);
    frame_clk = 1'b0;
    repeat (2) @(negedge Clk);
    model_frame(key, play, hv, g);
    compare_outputs();
  endtask

  task automatic probe_page(input string tag, input int exp_page);
    DrawX = 10'(X_LEFT); DrawY = PlayerTop; sprite_row = '1;
    #1;
    check(tag, 32'(sprite_addr), 32'(exp_page * HEIGHT));
    check({tag, "_pix"}, 32'(is_player), 32'd1);
  endtask

  initial begin
    int g, r;
    logic [7:0] key;
    model_reset();
    repeat (3) @(negedge Clk);
    check("rst_state", 32'(state_o), 32'(ST_IDLE));
    check("rst_top", 32'(PlayerTop), 32'(Y_RESET));
    check("rst_bottom", 32'(PlayerBottom), 32'(Y_RESET + HEIGHT));
    Reset_n = 1'b1;
    repeat (2) @(negedge Clk);

    // Start running; run pages step every FRAME_DIV frames and wrap.
    frame(8'h00, 1'b1, 1'b0, 330);
    check("to_run", 32'(state_o), 32'(ST_RUN));
    check("run_top", 32'(PlayerTop), 32'd250);
    for (int i = 0; i < 19; i++) frame(8'h00, 1'b1, 1'b0, 330);

    // Single jump: peak at 172 after twelve airborne frames, then land at 250.
    frame(K_JUMP, 1'b1, 1'b0, 330);
    for (int i = 0; i < 12; i++) frame(8'h00, 1'b1, 1'b0, 330);
    check("peak_top", 32'(PlayerTop), 32'd172);
    for (int i = 0; i < 16; i++) frame(8'h00, 1'b1, 1'b0, 330);
    check("land_top", 32'(PlayerTop), 32'd250);
    check("land_state", 32'(state_o), 32'(ST_RUN));

    // Jump key held through the whole jump: no relaunch.
    for (int i = 0; i < 30; i++) frame(K_JUMP, 1'b1, 1'b0, 330);
    frame(8'h00, 1'b1, 1'b0, 330);

    // Double jump, third press ignored until landing.
    frame(K_JUMP, 1'b1, 1'b0, 330);
    frame(8'h00, 1'b1, 1'b0, 330);
    frame(8'h00, 1'b1, 1'b0, 330);
    frame(K_JUMP, 1'b1, 1'b0, 330);
    frame(8'h00, 1'b1, 1'b0, 330);
    frame(K_JUMP, 1'b1, 1'b0, 330);
    for (int i = 0; i < 40; i++) frame(8'h00, 1'b1, 1'b0, 330);

    // Duck in RUN, then release.
    for (int i = 0; i < 3; i++) frame(K_DUCK, 1'b1, 1'b0, 330);
    check("duck_top", 32'(PlayerTop), 32'd282);
    check("duck_bottom", 32'(PlayerBottom), 32'd330);
    probe_page("duck_page", RUN_PAGES + 1);
    frame(8'h00, 1'b1, 1'b0, 330);
    check("unduck_top", 32'(PlayerTop), 32'd250);

    // Hit while airborne freezes the player; stopping the game returns to IDLE.
    frame(K_JUMP, 1'b1, 1'b0, 330);
    for (int i = 0; i < 3; i++) frame(8'h00, 1'b1, 1'b0, 330);
    for (int i = 0; i < 4; i++) frame(8'h00, 1'b1, 1'b1, 330);
    check("dead_top", 32'(PlayerTop), 32'd217);
    probe_page("dead_page", RUN_PAGES + 2);
    frame(8'h00, 1'b0, 1'b0, 330);
    check("stop_top", 32'(PlayerTop), 32'd250);

    // Ceiling clamp with a high floor.
    frame(8'h00, 1'b1, 1'b0, 100);
    frame(K_JUMP, 1'b1, 1'b0, 100);
    frame(8'h00, 1'b1, 1'b0, 100);
    check("ceil_top", 32'(PlayerTop), 32'(Y_MIN));
    for (int i = 0; i < 10; i++) frame(8'h00, 1'b1, 1'b0, 100);

    // Asynchronous reset in the middle of a jump, between clock edges.
    frame(8'h00, 1'b1, 1'b0, 330);
    frame(K_JUMP, 1'b1, 1'b0, 330);
    frame(8'h00, 1'b1, 1'b0, 330);
    frame(8'h00, 1'b1, 1'b0, 330);
    @(posedge Clk);
    #3 Reset_n = 1'b0;
    #1;
    check("async_state", 32'(state_o), 32'(ST_IDLE));
    check("async_top", 32'(PlayerTop), 32'd250);
    check("async_bottom", 32'(PlayerBottom), 32'd330);
    @(negedge Clk);
    Reset_n = 1'b1;
    model_reset();

    // Randomized frames.
    g = 330;
    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(15) == 0) g = 100 + int'($urandom_range(370));
      r = int'($urandom_range(9));
      key = (r < 4) ? 8'h00 : (r < 7) ? K_JUMP : (r < 9) ? K_DUCK : 8'($urandom);
      frame(key, $urandom_range(39) != 0, $urandom_range(59) == 0, g);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
